// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   start, bin    - conversion request and unsigned operand, taken only when idle
//   busy          - conversion in progress
//   done          - one-cycle pulse; bcd/ovf updated in this cycle
//   bcd           - packed digits, digit k at [4k+3:4k], digit 0 = units
//   ovf           - operand of last conversion did not fit in DIGITS digits
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DIGITS   = 5,
  parameter bit          LZ_BLANK = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 4 * DIGITS;

  typedef enum logic {ST_IDLE, ST_CONV} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_w_q, ovf_w_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_next;
  logic               out_bit;

  // Replace leading-zero digits (never digit 0) with 4'hF.
  function automatic logic [ACC_W-1:0] blank_lz(input logic [ACC_W-1:0] v);
    logic lead;
    lead     = 1'b1;
    blank_lz = v;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (lead && (v[4*k +: 4] == 4'd0)) begin
        blank_lz[4*k +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  endfunction

  // Add-3 correction per digit, then shift the next operand bit in; the top
  // accumulator bit falls out and marks overflow.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    {out_bit, acc_next} = {acc_adj, shift_q[WIDTH-1]};
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    ovf_w_d = ovf_w_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CONV;
          cnt_d   = CNT_W'(WIDTH);
          shift_d = bin;
          acc_d   = '0;
          ovf_w_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_CONV: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        acc_d   = acc_next;
        ovf_w_d = ovf_w_q | out_bit;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = LZ_BLANK ? blank_lz(acc_next) : acc_next;
          ovf_d   = ovf_w_q | out_bit;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      ovf_w_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      ovf_w_q <= ovf_w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: three instances (5 digits, 4 digits, 5 digits
// with leading-zero blanking) share clock, reset and stimulus; expected digits
// are hand-computed per vector.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin;

  logic        busy5, done5, ovf5;
  logic [19:0] bcd5;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;
  logic        busyz, donez, ovfz;
  logic [19:0] bcdz;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .LZ_BLANK(1'b0)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy5), .done(done5), .bcd(bcd5), .ovf(ovf5)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4), .LZ_BLANK(1'b0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .LZ_BLANK(1'b1)) u_dutz (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busyz), .done(donez), .bcd(bcdz), .ovf(ovfz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Vector table: operand, 5-digit bcd, 4-digit bcd, 4-digit ovf, blanked 5-digit bcd.
  typedef struct packed {
    logic [15:0] val;
    logic [19:0] e5;
    logic [15:0] e4;
    logic        o4;
    logic [19:0] ez;
  } vec_t;

  vec_t vecs [8];

  logic [19:0] prev5;
  logic [15:0] prev4;
  logic [19:0] prevz;

  // Run one conversion. If pre_accepted, the start for it is already on the
  // pins and the next rising edge accepts it. pulse_mode injects ignored start
  // pulses; hold_next keeps start high with next_val for a back-to-back start.
  task automatic conv(input vec_t v, input bit pre_accepted, input bit pulse_mode,
                      input bit hold_next, input logic [15:0] next_val);
    int  lat;
    int  busy_n;
    bit  got;
    if (!pre_accepted) begin
      @(negedge clk);
      start = 1'b1;
      bin   = v.val;
    end
    @(posedge clk);
    lat    = 0;
    busy_n = 0;
    got    = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (done5) begin
        got = 1'b1;
      end else begin
        if (busy5) busy_n++;
        if (lat == 8) begin
          check($sformatf("hold5_%0d", v.val), 32'(bcd5), 32'(prev5));
          check($sformatf("hold4_%0d", v.val), 32'(bcd4), 32'(prev4));
          check($sformatf("holdz_%0d", v.val), 32'(bcdz), 32'(prevz));
        end
        lat++;
      end
      if (hold_next) begin
        start = 1'b1;
        bin   = next_val;
      end else if (pulse_mode && (lat == 3 || lat == 9)) begin
        start = 1'b1;
        bin   = 16'd999;
      end else begin
        start = 1'b0;
        bin   = 16'hBEEF;
      end
    end
    check($sformatf("lat_%0d", v.val), 32'(lat), 32'd16);
    check($sformatf("busy_cycles_%0d", v.val), 32'(busy_n), 32'd16);
    check($sformatf("busy_in_done_%0d", v.val), 32'(busy5), 32'd0);
    check($sformatf("done_all_%0d", v.val), 32'({done4, donez}), 32'b11);
    check($sformatf("bcd5_%0d", v.val), 32'(bcd5), 32'(v.e5));
    check($sformatf("ovf5_%0d", v.val), 32'(ovf5), 32'd0);
    check($sformatf("bcd4_%0d", v.val), 32'(bcd4), 32'(v.e4));
    check($sformatf("ovf4_%0d", v.val), 32'(ovf4), 32'(v.o4));
    check($sformatf("bcdz_%0d", v.val), 32'(bcdz), 32'(v.ez));
    prev5 = v.e5;
    prev4 = v.e4;
    prevz = v.ez;
    if (!hold_next) begin
      @(negedge clk);
      check($sformatf("done_one_cycle_%0d", v.val), 32'(done5), 32'd0);
    end
  endtask

  initial begin
    int ndone;
    vecs[0] = '{val: 16'd65535, e5: 20'h65535, e4: 16'h5535, o4: 1'b1, ez: 20'h65535};
    vecs[1] = '{val: 16'd0,     e5: 20'h00000, e4: 16'h0000, o4: 1'b0, ez: 20'hFFFF0};
    vecs[2] = '{val: 16'd9999,  e5: 20'h09999, e4: 16'h9999, o4: 1'b0, ez: 20'hF9999};
    vecs[3] = '{val: 16'd10000, e5: 20'h10000, e4: 16'h0000, o4: 1'b1, ez: 20'h10000};
    vecs[4] = '{val: 16'd407,   e5: 20'h00407, e4: 16'h0407, o4: 1'b0, ez: 20'hFF407};
    vecs[5] = '{val: 16'd10,    e5: 20'h00010, e4: 16'h0010, o4: 1'b0, ez: 20'hFFF10};
    vecs[6] = '{val: 16'd123,   e5: 20'h00123, e4: 16'h0123, o4: 1'b0, ez: 20'hFF123};
    vecs[7] = '{val: 16'd45678, e5: 20'h45678, e4: 16'h5678, o4: 1'b1, ez: 20'h45678};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = 16'd0;
    prev5 = '0;
    prev4 = '0;
    prevz = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'({busy5, busy4, busyz}), 32'd0);
    check("rst_done", 32'({done5, done4, donez}), 32'd0);
    check("rst_bcd5", 32'(bcd5), 32'd0);
    check("rst_bcdz", 32'(bcdz), 32'd0);
    check("rst_ovf", 32'({ovf5, ovf4, ovfz}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain conversions, including the two ignored start pulses on 407.
    for (int i = 0; i < 6; i++) begin
      conv(vecs[i], 1'b0, (i == 4), 1'b0, 16'd0);
    end

    // Back-to-back: 123 with start held high carrying 45678.
    conv(vecs[6], 1'b0, 1'b0, 1'b1, vecs[7].val);
    conv(vecs[7], 1'b1, 1'b0, 1'b0, 16'd0);

    // Reset mid-conversion: outputs clear asynchronously, no done afterwards.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd9999;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'({busy5, busy4, busyz}), 32'd0);
    check("arst_done", 32'({done5, done4, donez}), 32'd0);
    check("arst_bcd5", 32'(bcd5), 32'd0);
    check("arst_bcd4", 32'(bcd4), 32'd0);
    check("arst_bcdz", 32'(bcdz), 32'd0);
    check("arst_ovf", 32'({ovf5, ovf4, ovfz}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done5 || done4 || donez || busy5) ndone++;
    end
    check("post_rst_quiet", 32'(ndone), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
